// File: rtl/win_addr_gen.sv
// Sliding-window read address generator for a K x K convolution pass over an
// IMG_H x IMG_W feature map held in a two-bank ping-pong buffer.
// Windows are visited in raster order; taps within a window in raster order.
// Optional build macro: WIN_STRIDE2_EN steps the window origin by 2 in both axes.
module win_addr_gen #(
    parameter int unsigned IMG_W     = 16,
    parameter int unsigned IMG_H     = 16,
    parameter int unsigned K         = 5,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BANK_SIZE = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bank_sel,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

`ifdef WIN_STRIDE2_EN
    localparam int unsigned STRIDE = 2;
`else
    localparam int unsigned STRIDE = 1;
`endif

    localparam int unsigned MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int unsigned PW      = $clog2(MAX_DIM + 1);
    localparam int unsigned KW      = $clog2(K + 1);

    // Last legal window origin: largest multiple of STRIDE that still fits the kernel
    localparam logic [PW-1:0] OCOL_LAST = PW'(((IMG_W - K) / STRIDE) * STRIDE);
    localparam logic [PW-1:0] OROW_LAST = PW'(((IMG_H - K) / STRIDE) * STRIDE);
    localparam logic [PW-1:0] STEP      = PW'(STRIDE);
    localparam logic [KW-1:0] K_LAST    = KW'(K - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              bank_q, bank_d;
    logic [PW-1:0]     orow_q, orow_d, ocol_q, ocol_d;
    logic [KW-1:0]     kr_q, kr_d, kc_q, kc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [PW-1:0]     orow_n, ocol_n;
    logic [KW-1:0]     kr_n, kc_n;
    logic              kc_wrap, kr_wrap, ocol_wrap, win_end, pass_end;

    // Full-width address; the bank offset sits above the in-bank word index
    function automatic logic [ADDR_W-1:0] calc_addr(input logic          bank,
                                                    input logic [PW-1:0] orow,
                                                    input logic [PW-1:0] ocol,
                                                    input logic [KW-1:0] kr,
                                                    input logic [KW-1:0] kc);
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        base = bank ? ADDR_W'(BANK_SIZE) : '0;
        row  = ADDR_W'(orow) + ADDR_W'(kr);
        col  = ADDR_W'(ocol) + ADDR_W'(kc);
        return base + row * ADDR_W'(IMG_W) + col;
    endfunction

    // Counter successors for one accepted address
    always_comb begin
        kc_wrap   = (kc_q == K_LAST);
        kr_wrap   = (kr_q == K_LAST);
        ocol_wrap = (ocol_q == OCOL_LAST);
        win_end   = kc_wrap && kr_wrap;
        pass_end  = win_end && ocol_wrap && (orow_q == OROW_LAST);
        kc_n      = kc_wrap ? '0 : kc_q + 1'b1;
        kr_n      = kc_wrap ? (kr_wrap ? '0 : kr_q + 1'b1) : kr_q;
        ocol_n    = win_end ? (ocol_wrap ? '0 : ocol_q + STEP) : ocol_q;
        orow_n    = (win_end && ocol_wrap) ? orow_q + STEP : orow_q;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    bank_d  = bank_sel;
                    orow_d  = '0;
                    ocol_d  = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    addr_d  = calc_addr(bank_sel, '0, '0, '0, '0);
                    valid_d = 1'b1;
                    last_d  = (K_LAST == '0);
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                if (valid_q && addr_ready) begin
                    if (pass_end) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        orow_d  = '0;
                        ocol_d  = '0;
                        kr_d    = '0;
                        kc_d    = '0;
                    end else begin
                        orow_d  = orow_n;
                        ocol_d  = ocol_n;
                        kr_d    = kr_n;
                        kc_d    = kc_n;
                        addr_d  = calc_addr(bank_q, orow_n, ocol_n, kr_n, kc_n);
                        last_d  = (kr_n == K_LAST) && (kc_n == K_LAST);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bank_q  <= 1'b0;
            orow_q  <= '0;
            ocol_q  <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr_out   = addr_q;
    assign addr_valid = valid_q;
    assign win_last   = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_win_addr_gen.sv
// Directed bench for win_addr_gen: reset, both banks, backpressure, ignored
// start pulses and reset in mid-pass. Honours WIN_STRIDE2_EN when defined.
module tb_win_addr_gen;

    localparam int IMG_W = 16;
    localparam int IMG_H = 16;
    localparam int K     = 5;
`ifdef WIN_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif
    localparam int NWC   = (IMG_W - K) / STRIDE + 1;
    localparam int NWR   = (IMG_H - K) / STRIDE + 1;
    localparam int TAPS  = K * K;
    localparam int TOTAL = NWC * NWR * TAPS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bank_sel = 1'b0;
    logic       addr_ready = 1'b0;
    logic [8:0] addr_out;
    logic       addr_valid;
    logic       win_last;
    logic       busy;
    logic       done;

    win_addr_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bank_sel   (bank_sel),
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .win_last   (win_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cap_addr [TOTAL+1];
    bit cap_last [TOTAL+1];
    int stall_addr [8];
    int hs, done_cnt, done_cyc, last_hs_cyc, end_cyc, stall_seen;

    // Reference address of the n-th handshake (1-based), derived from the index alone
    function automatic int exp_addr(input int n, input int base);
        int t, tap, win, orow, ocol;
        t    = n - 1;
        tap  = t % TAPS;
        win  = t / TAPS;
        orow = (win / NWC) * STRIDE;
        ocol = (win % NWC) * STRIDE;
        return base + (orow + tap / K) * IMG_W + ocol + tap % K;
    endfunction

    function automatic int seq_mismatches(input int base);
        int m;
        m = 0;
        for (int i = 1; i <= hs && i <= TOTAL; i++) begin
            if (cap_addr[i] != exp_addr(i, base)) m++;
            if (cap_last[i] != (((i - 1) % TAPS) == TAPS - 1)) m++;
        end
        return m;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives one pass and records what the consumer saw; no comparisons here
    task automatic run_pass(input bit bank, input int stall_at, input int stall_len,
                            input bit toggle, input int start_at, input bit start_in_done,
                            input int stop_after);
        int cyc;
        hs = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; stall_seen = 0;
        cyc = 0;
        bank_sel = bank; addr_ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        while (cyc < 20000 && !(hs >= TOTAL && !busy) && !(stop_after > 0 && hs >= stop_after))
        begin
            start = 1'b0;
            if (addr_valid) begin
                if (hs + 1 == stall_at && stall_seen < stall_len) begin
                    addr_ready = 1'b0;
                    if (stall_seen < 8) stall_addr[stall_seen] = int'(addr_out);
                    stall_seen++;
                end else begin
                    addr_ready = 1'b1;
                    hs++;
                    if (hs <= TOTAL) begin
                        cap_addr[hs] = int'(addr_out);
                        cap_last[hs] = win_last;
                    end
                    if (hs == TOTAL) last_hs_cyc = cyc;
                end
            end else begin
                addr_ready = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (start_in_done) start = 1'b1;
            end
            if (cyc == start_at) start = 1'b1;
            if (toggle) bank_sel = ~bank_sel;
            step;
            cyc++;
        end
        start = 1'b0;
        end_cyc = cyc;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step;
        step;
        checks++; if (addr_out !== 9'd0) begin errors++;
            $display("FAIL reset_addr: got %0d expected 0", addr_out); end
        checks++; if (addr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b expected 0", addr_valid); end
        checks++; if (win_last !== 1'b0) begin errors++;
            $display("FAIL reset_win_last: got %b expected 0", win_last); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL reset_done: got %b expected 0", done); end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_bank0;
        int m;
`ifndef WIN_STRIDE2_EN
        int first [6];
        first = '{0, 1, 2, 3, 4, 16};
`endif
        run_pass(1'b0, 0, 0, 1'b0, -1, 1'b0, 0);
        checks++; if (hs != TOTAL) begin errors++;
            $display("FAIL b0_count: got %0d expected %0d", hs, TOTAL); end
        checks++; if (done_cnt != 1) begin errors++;
            $display("FAIL b0_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc != last_hs_cyc + 1) begin errors++;
            $display("FAIL b0_done_timing: got %0d expected %0d", done_cyc, last_hs_cyc + 1); end
        checks++; if (end_cyc != done_cyc + 1) begin errors++;
            $display("FAIL b0_busy_fall: got %0d expected %0d", end_cyc, done_cyc + 1); end
        m = seq_mismatches(0);
        checks++; if (m != 0) begin errors++;
            $display("FAIL b0_sequence: got %0d bad entries expected 0", m); end
`ifndef WIN_STRIDE2_EN
        for (int i = 0; i < 6; i++) begin
            checks++; if (cap_addr[i+1] != first[i] || cap_last[i+1] != 1'b0) begin errors++;
                $display("FAIL b0_hs%0d: got %0d/%b expected %0d/0", i + 1, cap_addr[i+1],
                         cap_last[i+1], first[i]); end
        end
        checks++; if (cap_addr[25] != 68 || cap_last[25] != 1'b1) begin errors++;
            $display("FAIL b0_hs25: got %0d/%b expected 68/1", cap_addr[25], cap_last[25]); end
        checks++; if (cap_addr[26] != 1) begin errors++;
            $display("FAIL b0_hs26: got %0d expected 1", cap_addr[26]); end
        checks++; if (cap_addr[3600] != 255 || cap_last[3600] != 1'b1) begin errors++;
            $display("FAIL b0_last: got %0d/%b expected 255/1", cap_addr[3600], cap_last[3600]); end
`else
        checks++; if (cap_addr[26] != 2) begin errors++;
            $display("FAIL s2_hs26: got %0d expected 2", cap_addr[26]); end
        checks++; if (cap_addr[151] != 32) begin errors++;
            $display("FAIL s2_hs151: got %0d expected 32", cap_addr[151]); end
        checks++; if (cap_addr[900] != 238 || cap_last[900] != 1'b1) begin errors++;
            $display("FAIL s2_last: got %0d/%b expected 238/1", cap_addr[900], cap_last[900]); end
`endif
    endtask

    task automatic test_bank1;
        int m;
        int last_exp;
`ifdef WIN_STRIDE2_EN
        last_exp = 494;
`else
        last_exp = 511;
`endif
        run_pass(1'b1, 0, 0, 1'b1, -1, 1'b0, 0);
        checks++; if (cap_addr[1] != 256) begin errors++;
            $display("FAIL b1_first: got %0d expected 256", cap_addr[1]); end
        checks++; if (cap_addr[25] != 324) begin errors++;
            $display("FAIL b1_hs25: got %0d expected 324", cap_addr[25]); end
        checks++; if (cap_addr[TOTAL] != last_exp) begin errors++;
            $display("FAIL b1_last: got %0d expected %0d", cap_addr[TOTAL], last_exp); end
        m = seq_mismatches(256);
        checks++; if (m != 0 || hs != TOTAL) begin errors++;
            $display("FAIL b1_sequence: got %0d bad of %0d expected 0 of %0d", m, hs, TOTAL); end
        checks++; if (done_cnt != 1) begin errors++;
            $display("FAIL b1_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_backpressure;
        int m;
        int resume [5];
        resume = '{17, 18, 19, 20, 32};
        run_pass(1'b0, 7, 3, 1'b0, -1, 1'b0, 0);
        checks++; if (stall_seen != 3) begin errors++;
            $display("FAIL bp_stall_cycles: got %0d expected 3", stall_seen); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall_addr[i] != 17) begin errors++;
                $display("FAIL bp_hold%0d: got %0d expected 17", i, stall_addr[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (cap_addr[7+i] != resume[i]) begin errors++;
                $display("FAIL bp_hs%0d: got %0d expected %0d", 7 + i, cap_addr[7+i],
                         resume[i]); end
        end
        m = seq_mismatches(0);
        checks++; if (m != 0 || hs != TOTAL || done_cnt != 1) begin errors++;
            $display("FAIL bp_sequence: got %0d bad, %0d hs, %0d done expected 0, %0d, 1",
                     m, hs, done_cnt, TOTAL); end
    endtask

    task automatic test_start_ignored;
        int m;
        run_pass(1'b0, 0, 0, 1'b0, 50, 1'b1, 0);
        m = seq_mismatches(0);
        checks++; if (hs != TOTAL || m != 0) begin errors++;
            $display("FAIL si_sequence: got %0d hs %0d bad expected %0d hs 0 bad", hs, m, TOTAL); end
        checks++; if (done_cnt != 1) begin errors++;
            $display("FAIL si_done_pulses: got %0d expected 1", done_cnt); end
        step;
        checks++; if (addr_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL si_idle_after_done: got valid=%b busy=%b expected 0/0",
                     addr_valid, busy); end
    endtask

    task automatic test_reset_mid;
        run_pass(1'b0, 0, 0, 1'b0, -1, 1'b0, 100);
        checks++; if (hs != 100 || busy !== 1'b1) begin errors++;
            $display("FAIL rm_progress: got %0d hs busy=%b expected 100 busy=1", hs, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (addr_out !== 9'd0 || addr_valid !== 1'b0 || win_last !== 1'b0 ||
                      busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL rm_async_clear: got addr=%0d v=%b l=%b b=%b d=%b expected all 0",
                     addr_out, addr_valid, win_last, busy, done); end
        step;
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL rm_no_done: got %b expected 0", done); end
        rst_n = 1'b1;
        step;
        bank_sel = 1'b0; addr_ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        checks++; if (addr_valid !== 1'b1 || addr_out !== 9'd0) begin errors++;
            $display("FAIL rm_restart: got v=%b addr=%0d expected 1/0", addr_valid, addr_out); end
        step;
        checks++; if (addr_out !== 9'd1) begin errors++;
            $display("FAIL rm_restart_hs2: got %0d expected 1", addr_out); end
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        step;
    endtask

    initial begin
        test_reset;
        test_bank0;
        test_bank1;
        test_backpressure;
        test_start_ignored;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
